// File: rtl/hls_dl_pkg.sv
// hls_dl_pkg: shared types, widths and helpers for the deadlock confirmation unit.
package hls_dl_pkg;
    typedef enum logic [1:0] {DL_IDLE, DL_SUSPECT, DL_CONFIRMED} dl_state_e;
    localparam int DL_EVENT_CNT_W = 16;
    function automatic logic [63:0] onehot(input int id, input int width);
        return (id >= 0 && id < width) ? 64'(1) << id : 64'(0);
    endfunction
endpackage

// File: rtl/hls_dl_confirm_fsm.sv
// hls_dl_confirm_fsm: filters raw deadlock over CONFIRM_CYCLES cycles, captures the mask and pulses a report.
// Event counter built only when HLS_DL_EVENT_COUNTER_EN is defined.
module hls_dl_confirm_fsm
    import hls_dl_pkg::*;
#(
    parameter int PROC_NUM       = 4,
    parameter int CONFIRM_CYCLES = 4
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_raw,
    input  logic                      i_token_clear,
    input  logic [PROC_NUM-1:0]       i_dep,
    output logic                      o_dl_detect,
    output logic [PROC_NUM-1:0]       o_mask,
    output logic                      o_report,
    output logic [DL_EVENT_CNT_W-1:0] o_event_cnt
);
    localparam int CNT_W = $clog2(CONFIRM_CYCLES + 1);

    dl_state_e           r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_detect;
    logic [PROC_NUM-1:0] r_mask;
    logic                r_report;
    logic                w_enter;

    // token_clear outranks raw in IDLE/SUSPECT, so it also blocks entry
    assign w_enter = i_raw & ~i_token_clear &
                     ((r_state == DL_IDLE && CONFIRM_CYCLES == 1) ||
                      (r_state == DL_SUSPECT && r_cnt == CNT_W'(CONFIRM_CYCLES - 1)));

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= DL_IDLE;
            r_cnt    <= '0;
            r_detect <= 1'b0;
            r_mask   <= '0;
            r_report <= 1'b0;
        end else begin
            r_report <= w_enter;
            if (w_enter) begin
                r_state  <= DL_CONFIRMED;
                r_cnt    <= '0;
                r_detect <= 1'b1;
                r_mask   <= i_dep;
            end else begin
                case (r_state)
                    DL_IDLE: if (i_raw && !i_token_clear) begin
                        r_state <= DL_SUSPECT;
                        r_cnt   <= CNT_W'(1);
                    end
                    DL_SUSPECT: if (i_raw && !i_token_clear) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_state <= DL_IDLE;
                        r_cnt   <= '0;
                    end
                    DL_CONFIRMED: if (i_token_clear) begin
                        r_state  <= DL_IDLE;
                        r_cnt    <= '0;
                        r_detect <= 1'b0;
                    end
                    default: begin
                        r_state <= DL_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_dl_detect = r_detect;
    assign o_mask      = r_mask;
    assign o_report    = r_report;

`ifdef HLS_DL_EVENT_COUNTER_EN
    logic [DL_EVENT_CNT_W-1:0] r_event_cnt;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            r_event_cnt <= '0;
        else if (w_enter && r_event_cnt != '1)
            r_event_cnt <= r_event_cnt + 1'b1;
    end

    assign o_event_cnt = r_event_cnt;
`else
    assign o_event_cnt = '0;
`endif
endmodule

// File: rtl/hls_deadlock_confirm_unit.sv
// hls_deadlock_confirm_unit: per-process dependency merge/forward, token relay and confirmed deadlock reporting.
// Optional confirmed-event counter enabled by HLS_DL_EVENT_COUNTER_EN.
module hls_deadlock_confirm_unit
    import hls_dl_pkg::*;
#(
    parameter int PROC_NUM       = 4,
    parameter int PROC_ID        = 0,
    parameter int IN_CHAN_NUM    = 2,
    parameter int OUT_CHAN_NUM   = 3,
    parameter int CONFIRM_CYCLES = 4
) (
    input  logic                            reset,
    input  logic                            clock,
    input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
    input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
    input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
    input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
    input  logic                            dl_detect_in,
    input  logic                            origin,
    input  logic                            token_clear,
    output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
    output logic [PROC_NUM-1:0]             out_chan_dep_data,
    output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
    output logic                            dl_detect_out,
    output logic [PROC_NUM-1:0]             dl_cycle_mask,
    output logic                            dl_report_vld,
    output logic [DL_EVENT_CNT_W-1:0]       dl_event_cnt
);
    localparam logic [PROC_NUM-1:0] SELF = PROC_NUM'(onehot(PROC_ID, PROC_NUM));

    logic [PROC_NUM-1:0]     r_dep_reg;
    logic [OUT_CHAN_NUM-1:0] r_token_out;
    logic [PROC_NUM-1:0]     w_merged;
    logic [PROC_NUM-1:0]     w_dep;
    logic                    w_gate;
    logic                    w_blocked;
    logic                    w_raw;

    always_comb begin
        w_merged = '0;
        for (int i = 0; i < IN_CHAN_NUM; i++)
            w_merged |= {PROC_NUM{in_chan_dep_vld_vec[i]}} & in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM];
    end

    // once a deadlock is globally known, only token holders refresh their view
    assign w_gate    = ~dl_detect_in | (|token_in_vec);
    assign w_dep     = w_gate ? w_merged : r_dep_reg;
    assign w_blocked = |proc_dep_vld_vec;
    assign w_raw     = w_gate & w_dep[PROC_ID] & w_blocked;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dep_reg   <= '0;
            r_token_out <= '0;
        end else begin
            r_dep_reg   <= w_blocked ? w_dep : '0;
            r_token_out <= (((|token_in_vec) & ~token_clear) | origin) ? proc_dep_vld_vec : '0;
        end
    end

    assign out_chan_dep_vld_vec = proc_dep_vld_vec;
    assign out_chan_dep_data    = r_dep_reg | SELF;
    assign token_out_vec        = r_token_out;

    hls_dl_confirm_fsm #(
        .PROC_NUM      (PROC_NUM),
        .CONFIRM_CYCLES(CONFIRM_CYCLES)
    ) u_fsm (
        .i_clock      (clock),
        .i_reset_n    (reset),
        .i_raw        (w_raw),
        .i_token_clear(token_clear),
        .i_dep        (w_dep),
        .o_dl_detect  (dl_detect_out),
        .o_mask       (dl_cycle_mask),
        .o_report     (dl_report_vld),
        .o_event_cnt  (dl_event_cnt)
    );
endmodule

// File: doc/hls_deadlock_confirm_unit.md
Name: hls_deadlock_confirm_unit

Overview:
- Successor to the per-process HLS deadlock detection unit.
- Each instance sits beside one dataflow process and does three things: merges dependency bits from incoming channels, forwards its own dependency set downstream, and passes report tokens on.
- New in this generation: a deadlock must persist for a parametrised number of cycles before it is reported, which filters transient stalls. The block also captures the dependency mask at confirmation and emits a one-cycle report pulse.

Parameters:
- PROC_NUM, 4: number of processes; width of dependency vectors.
- PROC_ID, 0: index of the owning process (0..PROC_NUM-1).
- IN_CHAN_NUM, 2: incoming dependency channels.
- OUT_CHAN_NUM, 3: outgoing dependency channels.
- CONFIRM_CYCLES, 4: consecutive raw-deadlock cycles required before confirmation; must be >= 1.
- CNT_W, $clog2(CONFIRM_CYCLES+1): width of the confirmation counter (derived localparam).

Ports:
- reset  in  1  asynchronous, active-low.
- clock  in  1  clock; all state updates on rising edge.
- proc_dep_vld_vec  in  OUT_CHAN_NUM  process is blocked on each outgoing channel.
- in_chan_dep_vld_vec  in  IN_CHAN_NUM  incoming dependency data is valid, per channel.
- in_chan_dep_data_vec  in  IN_CHAN_NUM*PROC_NUM  incoming dependency sets; channel i occupies slice [i*PROC_NUM +: PROC_NUM].
- token_in_vec  in  IN_CHAN_NUM  report tokens from upstream.
- dl_detect_in  in  1  global "deadlock already detected" flag.
- origin  in  1  this unit originates the token.
- token_clear  in  1  clears tokens and confirmed state.
- out_chan_dep_vld_vec  out  OUT_CHAN_NUM  equals proc_dep_vld_vec (combinational).
- out_chan_dep_data  out  PROC_NUM  dep_reg OR one-hot(PROC_ID).
- token_out_vec  out  OUT_CHAN_NUM  registered tokens to downstream.
- dl_detect_out  out  1  registered; high while in CONFIRMED.
- dl_cycle_mask  out  PROC_NUM  dependency set captured at confirmation.
- dl_report_vld  out  1  one-cycle pulse on entry to CONFIRMED.
- dl_event_cnt  out  16  count of confirmed deadlocks; see Optional Feature.

Behaviour:
- Reset (async, reset=0): dep_reg, token_out_vec, counter, dl_detect_out, dl_cycle_mask, dl_report_vld and dl_event_cnt all clear to 0; FSM goes to IDLE. During reset, out_chan_dep_data = one-hot(PROC_ID).
- Reset asserted mid-count or while CONFIRMED aborts immediately. There is no memory of prior state after reset.
- gate = ~dl_detect_in | (|token_in_vec).
- merged = OR over i of ({PROC_NUM{in_chan_dep_vld_vec[i]}} & slice i).
- dep = gate ? merged : dep_reg.
- dep_reg <= (|proc_dep_vld_vec) ? dep : 0. Dependency latency is 1 cycle from the inputs to out_chan_dep_data.
- raw = gate & dep[PROC_ID] & (|proc_dep_vld_vec).
- FSM states: IDLE, SUSPECT, CONFIRMED.
  - IDLE: on raw, go to SUSPECT with cnt=1. If CONFIRM_CYCLES==1, go directly to CONFIRMED instead.
  - SUSPECT: if raw and cnt==CONFIRM_CYCLES-1, go to CONFIRMED. Else if raw, cnt++. If ~raw, go to IDLE with cnt=0.
  - CONFIRMED: hold until token_clear, then go to IDLE with cnt=0. Raw is ignored in this state.
- Confirmation timing: raw high in cycles 0..N-1 (N=CONFIRM_CYCLES) gives dl_detect_out=1 from cycle N.
- On the CONFIRMED entry edge: dl_cycle_mask <= dep, dl_report_vld <= 1 for exactly one cycle.
- dl_cycle_mask holds its value until the next confirmation; it is not cleared by token_clear.
- token_clear in IDLE or SUSPECT forces IDLE with cnt=0 and takes priority over raw.
- Tokens: token_out_vec <= proc_dep_vld_vec when ((|token_in_vec) & ~token_clear) | origin; otherwise 0. origin overrides token_clear.
- Counter never exceeds CONFIRM_CYCLES-1. No wrap is possible.

Optional Feature:
- Macro: HLS_DL_EVENT_COUNTER_EN.
- Defined: dl_event_cnt increments by 1 on every CONFIRMED entry and saturates at 16'hFFFF. It is cleared only by reset.
- Undefined: the counter logic is not built, and dl_event_cnt is tied to 16'h0.

Decomposition:
- Package hls_dl_pkg holds:
  - the state enum (DL_IDLE, DL_SUSPECT, DL_CONFIRMED);
  - DL_EVENT_CNT_W=16;
  - a function onehot(id, width).
- Sub-module hls_dl_confirm_fsm contains the state register, confirmation counter, mask capture, report pulse and optional event counter.
  - Inputs: raw, token_clear, dep.
- Top level keeps the dependency merge, dep_reg and token logic.

Test Plan:
- Common configuration: PROC_NUM=4, PROC_ID=1, IN=2, OUT=3, CONFIRM_CYCLES=4.
- Reset release with all inputs 0 -> all outputs 0 except out_chan_dep_data=4'b0010.
- proc_dep_vld=3'b001, in_vld=2'b01, ch0 data=4'b0100, dl_detect_in=0 -> next cycle out_chan_dep_data=4'b0110; dl_detect_out stays 0.
- ch0 data=4'b0010 held with proc_dep_vld=3'b001 -> dl_detect_out rises at edge 4; dl_cycle_mask=4'b0010; dl_report_vld high for exactly 1 cycle.
- Raw high for 3 cycles, then 1 cycle low, then high again -> no detect until 4 further consecutive cycles.
- origin=1, proc_dep_vld=3'b101 -> token_out_vec=3'b101. Then origin=0, token_in=2'b01, token_clear=1 -> 3'b000.
- CONFIRMED then token_clear -> IDLE, dl_detect_out=0 next cycle. With macro defined, dl_event_cnt=1 (2 after a repeat); without it, dl_event_cnt=0 throughout.
